// File: rtl/frame_buf_pingpong_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : frame_buf_pingpong_pkg                                 |
// | Description : Shared types and default sizes for the ping-pong frame |
// |               buffer (bank-select encoding, default widths).         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package frame_buf_pingpong_pkg;

   // Which physical bank is meant by a bank-select value
   typedef enum logic {
      BANK0 = 1'b0,
      BANK1 = 1'b1
   } bank_e;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_ADDR_WIDTH = 3;
   localparam int DEF_CNT_WIDTH  = 8;

endpackage
`default_nettype wire

// File: rtl/fb_ram_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fb_ram_bank                                            |
// | Description : Simple dual-port RAM bank: synchronous write, one-cycle |
// |               registered read. Only the read register is reset.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fb_ram_bank #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_d;
   logic [DATA_WIDTH-1:0] rdata_q;

   // Storage array: contents survive reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Read register keeps its last word when no read is issued
   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[raddr];
      end
   end

   // Read register state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/frame_buf_pingpong.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : frame_buf_pingpong                                     |
// | Description : Double-buffered frame memory. The writer fills one bank |
// |               while the reader drains the other; banks swap once the |
// |               writer has finished and the reader has released.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module frame_buf_pingpong
   import frame_buf_pingpong_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_done,
   output logic                  wr_ready,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   input  logic                  rd_done,
   output logic                  frame_avail,
   output logic                  wr_drop,
   output logic [CNT_WIDTH-1:0]  frame_cnt
);

   bank_e                 sel_d, sel_q;          // current write bank
   bank_e                 rd_bank_d, rd_bank_q;  // bank whose read register drives rd_data
   logic                  wf_d, wf_q;            // writer finished its frame
   logic                  rf_d, rf_q;            // reader released its frame
   logic                  avail_d, avail_q;
   logic                  drop_d, drop_q;
   logic                  rvalid_d, rvalid_q;
   logic [CNT_WIDTH-1:0]  cnt_d, cnt_q;

   logic                  wr_acc;
   logic                  rd_acc;
   logic                  swap;
   logic                  we0, we1, re0, re1;
   logic [DATA_WIDTH-1:0] rdata0, rdata1;

   // Swap control: flags, bank select, counters, and bank steering
   always_comb begin
      wr_acc    = wr_en & ~wf_q;
      rd_acc    = rd_en & avail_q;
      swap      = wf_q & (rf_q | ~avail_q);

      sel_d     = sel_q;
      wf_d      = wf_q;
      rf_d      = rf_q;
      avail_d   = avail_q;
      cnt_d     = cnt_q;
      drop_d    = drop_q | (wr_en & wf_q);
      rvalid_d  = rd_acc;
      rd_bank_d = rd_acc ? bank_e'(~sel_q) : rd_bank_q;

      if (swap) begin
         // Done pulses on the swap edge are ignored: their flags are set or clearing
         sel_d   = bank_e'(~sel_q);
         wf_d    = 1'b0;
         rf_d    = 1'b0;
         avail_d = 1'b1;
         cnt_d   = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         if (wr_done && !wf_q) begin
            wf_d = 1'b1;
         end
         if (rd_done && avail_q && !rf_q) begin
            rf_d = 1'b1;
         end
      end

      we0 = wr_acc & (sel_q == BANK0);
      we1 = wr_acc & (sel_q == BANK1);
      re0 = rd_acc & (sel_q == BANK1);
      re1 = rd_acc & (sel_q == BANK0);
   end

   // Control state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q     <= BANK0;
         rd_bank_q <= BANK0;
         wf_q      <= 1'b0;
         rf_q      <= 1'b0;
         avail_q   <= 1'b0;
         drop_q    <= 1'b0;
         rvalid_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         sel_q     <= sel_d;
         rd_bank_q <= rd_bank_d;
         wf_q      <= wf_d;
         rf_q      <= rf_d;
         avail_q   <= avail_d;
         drop_q    <= drop_d;
         rvalid_q  <= rvalid_d;
         cnt_q     <= cnt_d;
      end
   end

   fb_ram_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_bank0 (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we0),
      .waddr (wr_addr),
      .wdata (wr_data),
      .re    (re0),
      .raddr (rd_addr),
      .rdata (rdata0)
   );

   fb_ram_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_bank1 (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we1),
      .waddr (wr_addr),
      .wdata (wr_data),
      .re    (re1),
      .raddr (rd_addr),
      .rdata (rdata1)
   );

   assign wr_ready    = ~wf_q;
   assign frame_avail = avail_q;
   assign wr_drop     = drop_q;
   assign rd_valid    = rvalid_q;
   assign frame_cnt   = cnt_q;
   assign rd_data     = (rd_bank_q == BANK1) ? rdata1 : rdata0;

endmodule
`default_nettype wire

// File: tb/tb_frame_buf_pingpong.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_frame_buf_pingpong                                  |
// | Description : Scoreboard bench for frame_buf_pingpong: a frame-level |
// |               reference model queues expected outputs per cycle and  |
// |               a monitor compares them against the DUT.               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_frame_buf_pingpong;

   localparam int DW = 16;
   localparam int AW = 3;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_en, wr_done, rd_en, rd_done;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ready, rd_valid, frame_avail, wr_drop;
   logic [DW-1:0] rd_data;
   logic [CW-1:0] frame_cnt;

   always #5 clk = ~clk;

   frame_buf_pingpong #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .CNT_WIDTH (CW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_done     (wr_done),
      .wr_ready    (wr_ready),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .rd_done     (rd_done),
      .frame_avail (frame_avail),
      .wr_drop     (wr_drop),
      .frame_cnt   (frame_cnt)
   );

   typedef struct {
      logic          v;
      logic [DW-1:0] d;
      logic          rdy;
      logic          av;
      logic [CW-1:0] cnt;
      logic          drop;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   bit   mon_en = 1'b0;

   // Reference model: one frame store per bank plus the handshake state
   logic [DW-1:0] m_mem [2][8];
   bit            m_sel, m_wf, m_rf, m_avail, m_drop, m_rv;
   logic [DW-1:0] m_rd;
   logic [CW-1:0] m_cnt;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_sel = 1'b0; m_wf = 1'b0; m_rf = 1'b0; m_avail = 1'b0;
      m_drop = 1'b0; m_rv = 1'b0; m_rd = '0; m_cnt = '0;
   endtask

   // One clock of stimulus; the expected post-edge outputs go to the scoreboard
   task automatic cyc(input bit we, input int wa, input logic [DW-1:0] wd, input bit wdn,
                      input bit re, input int ra, input bit rdn);
      exp_t e;
      bit   swp;
      @(negedge clk); #1;
      wr_en = we; wr_addr = AW'(wa); wr_data = wd; wr_done = wdn;
      rd_en = re; rd_addr = AW'(ra); rd_done = rdn;
      swp = m_wf && (m_rf || !m_avail);
      if (re && m_avail) begin
         m_rd = m_mem[!m_sel][wa_fix(ra)];
         m_rv = 1'b1;
      end else begin
         m_rv = 1'b0;
      end
      if (we) begin
         if (!m_wf) m_mem[m_sel][wa_fix(wa)] = wd;
         else       m_drop = 1'b1;
      end
      if (swp) begin
         m_sel = !m_sel; m_wf = 1'b0; m_rf = 1'b0; m_avail = 1'b1; m_cnt = m_cnt + 1'b1;
      end else begin
         if (wdn && !m_wf) m_wf = 1'b1;
         if (rdn && m_avail && !m_rf) m_rf = 1'b1;
      end
      e.v = m_rv; e.d = m_rd; e.rdy = !m_wf; e.av = m_avail; e.cnt = m_cnt; e.drop = m_drop;
      exp_q.push_back(e);
   endtask

   function automatic int wa_fix(input int a);
      return a % 8;
   endfunction

   task automatic idle();
      cyc(0, 0, '0, 0, 0, 0, 0);
   endtask

   task automatic write_frame(input logic [DW-1:0] base, input int n);
      for (int i = 0; i < n; i++) cyc(1, i, base + DW'(i), 0, 0, 0, 0);
   endtask

   task automatic read_frame();
      for (int i = 0; i < 8; i++) cyc(0, 0, '0, 0, 1, i, 0);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_wr_ready"}, 32'(wr_ready), 1);
      chk({tag, "_frame_avail"}, 32'(frame_avail), 0);
      chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
      chk({tag, "_rd_data"}, 32'(rd_data), 0);
      chk({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
      chk({tag, "_wr_drop"}, 32'(wr_drop), 0);
   endtask

   // Monitor: compare DUT outputs with the queued expectation each cycle
   always @(negedge clk) begin
      exp_t e;
      if (mon_en && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("rd_valid", 32'(rd_valid), 32'(e.v));
         chk("rd_data", 32'(rd_data), 32'(e.d));
         chk("wr_ready", 32'(wr_ready), 32'(e.rdy));
         chk("frame_avail", 32'(frame_avail), 32'(e.av));
         chk("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
         chk("wr_drop", 32'(wr_drop), 32'(e.drop));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      wr_en = 0; wr_addr = '0; wr_data = '0; wr_done = 0;
      rd_en = 0; rd_addr = '0; rd_done = 0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      @(negedge clk); rst_n = 1'b1; mon_en = 1'b1;

      // Reads with no frame available return nothing
      cyc(0, 0, '0, 0, 1, 2, 0);
      cyc(0, 0, '0, 0, 1, 5, 0);

      // First frame, swap one edge after wr_done
      write_frame(16'h0001, 8);
      cyc(0, 0, '0, 1, 0, 0, 0);
      idle();
      idle();
      chk("first_swap_cnt", 32'(frame_cnt), 1);
      chk("first_swap_avail", 32'(frame_avail), 1);
      read_frame();

      // Held frame: no swap without rd_done, extra write is dropped
      write_frame(16'h0011, 8);
      cyc(0, 0, '0, 1, 0, 0, 0);
      idle();
      idle();
      chk("hold_ready", 32'(wr_ready), 0);
      chk("hold_cnt", 32'(frame_cnt), 1);
      cyc(1, 3, 16'hBEEF, 0, 0, 0, 0);
      idle();
      chk("hold_drop", 32'(wr_drop), 1);
      read_frame();

      // Release swaps on the next edge
      cyc(0, 0, '0, 0, 0, 0, 1);
      idle();
      idle();
      chk("release_cnt", 32'(frame_cnt), 2);
      chk("release_ready", 32'(wr_ready), 1);
      read_frame();

      // Swap-edge collision: read uses old bank, write is dropped
      write_frame(16'h0021, 8);
      cyc(0, 0, '0, 1, 0, 0, 0);
      cyc(0, 0, '0, 0, 0, 0, 1);
      cyc(1, 0, 16'hDEAD, 0, 1, 3, 0);
      idle();
      chk("collide_cnt", 32'(frame_cnt), 3);
      cyc(0, 0, '0, 0, 0, 0, 1);
      cyc(0, 0, '0, 1, 0, 0, 0);
      idle();
      idle();
      read_frame();

      // Async reset mid-frame while a swap is pending
      write_frame(16'h0031, 4);
      cyc(0, 0, '0, 1, 0, 0, 0);
      idle();
      @(negedge clk); #1;
      mon_en = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset_state("async");
      exp_q.delete();
      model_reset();
      wr_en = 0; wr_done = 0; rd_en = 0; rd_done = 0;
      @(negedge clk); rst_n = 1'b1; mon_en = 1'b1;

      // Partial frame after reset lands in bank0; the rest shows older contents
      write_frame(16'h0041, 4);
      cyc(0, 0, '0, 1, 0, 0, 0);
      idle();
      read_frame();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 1) == 1, int'($urandom_range(0, 7)), DW'($urandom),
             $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
             int'($urandom_range(0, 7)), $urandom_range(0, 7) == 0);
      end

      // Rapid frames to wrap the frame counter
      for (int i = 0; i < 260; i++) begin
         cyc($urandom_range(0, 1) == 1, int'($urandom_range(0, 7)), DW'($urandom), 1,
             0, 0, 1);
         cyc(0, 0, '0, 0, 1, int'($urandom_range(0, 7)), 0);
      end

      idle();
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
